// File: rtl/vga_pkg.sv
// Shared VGA timing constants (800x600@72) and pixel colour type.
// Painters and the scan controller import this package so that timing is defined once.
package vga_pkg;

  localparam int VGA_WIDTH = 12;

  localparam int HSIZE = 800;
  localparam int HFP   = 856;
  localparam int HSP   = 976;
  localparam int HMAX  = 1040;
  localparam int VSIZE = 600;
  localparam int VFP   = 637;
  localparam int VSP   = 643;
  localparam int VMAX  = 666;

  localparam bit HSPP = 1'b1;
  localparam bit VSPP = 1'b1;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

endpackage

// File: rtl/vga_scan_controller_if.sv
// Raster bus between the scan controller, the painters and the VGA DAC.
// The master modport is the scan controller side.
interface vga_scan_controller_if #(
  parameter int VGA_WIDTH = vga_pkg::VGA_WIDTH
);
  logic [VGA_WIDTH-1:0] hdata;
  logic [VGA_WIDTH-1:0] vdata;
  logic [7:0]           pixel_red;
  logic [7:0]           pixel_green;
  logic [7:0]           pixel_blue;
  logic [7:0]           video_red;
  logic [7:0]           video_green;
  logic [7:0]           video_blue;
  logic                 video_hsync;
  logic                 video_vsync;
  logic                 video_de;
  logic                 line_start;
  logic                 frame_start;

  modport master (
    output hdata, vdata,
    input  pixel_red, pixel_green, pixel_blue,
    output video_red, video_green, video_blue,
    output video_hsync, video_vsync, video_de,
    output line_start, frame_start
  );

  modport slave (
    input  hdata, vdata,
    output pixel_red, pixel_green, pixel_blue,
    input  video_red, video_green, video_blue,
    input  video_hsync, video_vsync, video_de,
    input  line_start, frame_start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: enabled counter wrapping at MAX-1, plus sync-pulse and active-window decode.
// Used once for the horizontal axis and once for the vertical axis.
module vga_axis_counter #(
  parameter int WIDTH = 12,
  parameter int SIZE  = 800,
  parameter int FP    = 856,
  parameter int SP    = 976,
  parameter int MAX   = 1040,
  parameter bit SPP   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             sync,
  output logic             active,
  output logic             first
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  // One extra bit so SP or SIZE equal to 2**WIDTH still compare correctly.
  localparam logic [WIDTH:0] SIZE_C = (WIDTH + 1)'(SIZE);
  localparam logic [WIDTH:0] FP_C   = (WIDTH + 1)'(FP);
  localparam logic [WIDTH:0] SP_C   = (WIDTH + 1)'(SP);

  if (longint'(MAX) - 1 >= (longint'(1) << WIDTH)) begin : g_bad_width
    $error("vga_axis_counter: MAX-1 does not fit in WIDTH bits");
  end

  if (!(SIZE <= FP && FP < SP && SP <= MAX)) begin : g_bad_order
    $error("vga_axis_counter: need SIZE <= FP < SP <= MAX");
  end

  logic [WIDTH:0] count_x;

  assign count_x = {1'b0, count};
  assign wrap    = en && (count == LAST);
  assign sync    = (count_x >= FP_C && count_x < SP_C) ? SPP : ~SPP;
  assign active  = count_x < SIZE_C;
  assign first   = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/vga_scan_controller.sv
// Raster scan controller: drives painter coordinates and registers colour, sync, DE
// and line/frame pulses so that they all leave one pix_ce cycle after their coordinate.
module vga_scan_controller #(
  parameter int VGA_WIDTH = vga_pkg::VGA_WIDTH,
  parameter int HSIZE     = vga_pkg::HSIZE,
  parameter int HFP       = vga_pkg::HFP,
  parameter int HSP       = vga_pkg::HSP,
  parameter int HMAX      = vga_pkg::HMAX,
  parameter int VSIZE     = vga_pkg::VSIZE,
  parameter int VFP       = vga_pkg::VFP,
  parameter int VSP       = vga_pkg::VSP,
  parameter int VMAX      = vga_pkg::VMAX,
  parameter bit HSPP      = vga_pkg::HSPP,
  parameter bit VSPP      = vga_pkg::VSPP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_ce,
  vga_scan_controller_if.master bus
);

  import vga_pkg::*;

  logic [VGA_WIDTH-1:0] hcount;
  logic [VGA_WIDTH-1:0] vcount;
  logic h_wrap, h_sync, h_active, h_first;
  logic v_sync, v_active, v_first;
  logic de0;

  rgb_t pixel;
  rgb_t colour;
  logic hsync_q, vsync_q, de_q, line_q, frame_q;

  vga_axis_counter #(
    .WIDTH(VGA_WIDTH), .SIZE(HSIZE), .FP(HFP), .SP(HSP), .MAX(HMAX), .SPP(HSPP)
  ) u_h (
    .clk(clk), .reset(reset), .en(pix_ce),
    .count(hcount), .wrap(h_wrap), .sync(h_sync), .active(h_active), .first(h_first)
  );

  // Vertical axis steps only on the last pixel of a line.
  vga_axis_counter #(
    .WIDTH(VGA_WIDTH), .SIZE(VSIZE), .FP(VFP), .SP(VSP), .MAX(VMAX), .SPP(VSPP)
  ) u_v (
    .clk(clk), .reset(reset), .en(pix_ce & h_wrap),
    .count(vcount), .wrap(), .sync(v_sync), .active(v_active), .first(v_first)
  );

  assign de0         = h_active & v_active;
  assign pixel.red   = bus.pixel_red;
  assign pixel.green = bus.pixel_green;
  assign pixel.blue  = bus.pixel_blue;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      colour  <= '0;
      hsync_q <= ~HSPP;
      vsync_q <= ~VSPP;
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else if (pix_ce) begin
      colour  <= de0 ? pixel : '0;
      hsync_q <= h_sync;
      vsync_q <= v_sync;
      de_q    <= de0;
      line_q  <= h_first;
      frame_q <= h_first & v_first;
    end
  end

  assign bus.hdata       = hcount;
  assign bus.vdata       = vcount;
  assign bus.video_red   = colour.red;
  assign bus.video_green = colour.green;
  assign bus.video_blue  = colour.blue;
  assign bus.video_hsync = hsync_q;
  assign bus.video_vsync = vsync_q;
  assign bus.video_de    = de_q;
  assign bus.line_start  = line_q;
  assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench: default timing, a tiny 8x5 raster, and the same raster with low-active syncs.
module tb_vga_scan_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_ce_d = 1'b0;
  logic pix_ce_s = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_scan_controller_if bus_d ();
  vga_scan_controller_if bus_s ();
  vga_scan_controller_if bus_n ();

  assign bus_d.pixel_red   = 8'hff;
  assign bus_d.pixel_green = 8'hff;
  assign bus_d.pixel_blue  = 8'hff;
  assign bus_s.pixel_red   = bus_s.hdata[7:0];
  assign bus_s.pixel_green = 8'hff;
  assign bus_s.pixel_blue  = 8'hff;
  assign bus_n.pixel_red   = bus_n.hdata[7:0];
  assign bus_n.pixel_green = 8'hff;
  assign bus_n.pixel_blue  = 8'hff;

  vga_scan_controller dut_d (
    .clk(clk), .reset(reset), .pix_ce(pix_ce_d), .bus(bus_d)
  );

  vga_scan_controller #(
    .HSIZE(4), .HFP(5), .HSP(6), .HMAX(8), .VSIZE(2), .VFP(3), .VSP(4), .VMAX(5)
  ) dut_s (
    .clk(clk), .reset(reset), .pix_ce(pix_ce_s), .bus(bus_s)
  );

  vga_scan_controller #(
    .HSIZE(4), .HFP(5), .HSP(6), .HMAX(8), .VSIZE(2), .VFP(3), .VSP(4), .VMAX(5),
    .HSPP(1'b0), .VSPP(1'b0)
  ) dut_n (
    .clk(clk), .reset(reset), .pix_ce(pix_ce_s), .bus(bus_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs expected after the edge that consumed coordinate index c (have=0: reset state).
  task automatic chk_small(input int c, input bit have);
    int h, v;
    bit de;
    h  = c % 8;
    v  = (c / 8) % 5;
    de = have && h < 4 && v < 2;
    chk("s_hdata", 32'(bus_s.hdata), have ? (c + 1) % 8 : 0);
    chk("s_vdata", 32'(bus_s.vdata), have ? ((c + 1) / 8) % 5 : 0);
    chk("s_red",   32'(bus_s.video_red),   de ? h : 0);
    chk("s_green", 32'(bus_s.video_green), de ? 32'hff : 0);
    chk("s_blue",  32'(bus_s.video_blue),  de ? 32'hff : 0);
    chk("s_de",    32'(bus_s.video_de),    32'(de));
    chk("s_hsync", 32'(bus_s.video_hsync), 32'(have && h == 5));
    chk("s_vsync", 32'(bus_s.video_vsync), 32'(have && v == 3));
    chk("s_line",  32'(bus_s.line_start),  32'(have && h == 0));
    chk("s_frame", 32'(bus_s.frame_start), 32'(have && h == 0 && v == 0));
    chk("n_hsync", 32'(bus_n.video_hsync), 32'(!(have && h == 5)));
    chk("n_vsync", 32'(bus_n.video_vsync), 32'(!(have && v == 3)));
    chk("n_de",    32'(bus_n.video_de),    32'(de));
    chk("n_red",   32'(bus_n.video_red),   de ? h : 0);
  endtask

  task automatic chk_dflt(input int c, input bit have);
    int h, v;
    bit de;
    h  = c % 1040;
    v  = (c / 1040) % 666;
    de = have && h < 800 && v < 600;
    chk("d_hdata", 32'(bus_d.hdata), have ? (c + 1) % 1040 : 0);
    chk("d_vdata", 32'(bus_d.vdata), have ? ((c + 1) / 1040) % 666 : 0);
    chk("d_red",   32'(bus_d.video_red),   de ? 32'hff : 0);
    chk("d_blue",  32'(bus_d.video_blue),  de ? 32'hff : 0);
    chk("d_de",    32'(bus_d.video_de),    32'(de));
    chk("d_hsync", 32'(bus_d.video_hsync), 32'(have && h >= 856 && h < 976));
    chk("d_vsync", 32'(bus_d.video_vsync), 32'(have && v >= 637 && v < 643));
    chk("d_line",  32'(bus_d.line_start),  32'(have && h == 0));
    chk("d_frame", 32'(bus_d.frame_start), 32'(have && h == 0 && v == 0));
  endtask

  initial begin
    int c;
    int kidx;
    bit have;

    repeat (3) step();
    chk_small(0, 1'b0);
    chk_dflt(0, 1'b0);

    reset    = 1'b0;
    pix_ce_d = 1'b1;
    pix_ce_s = 1'b1;
    for (int k = 0; k < 1100; k++) begin
      step();
      chk_dflt(k, 1'b1);
      chk_small(k, 1'b1);
    end

    // Mid-frame reset must clear outputs without waiting for a clock edge.
    reset = 1'b1;
    #1;
    chk_small(0, 1'b0);
    chk_dflt(0, 1'b0);
    repeat (3) begin
      step();
      chk_small(0, 1'b0);
      chk_dflt(0, 1'b0);
    end

    pix_ce_d = 1'b0;
    reset    = 1'b0;
    kidx     = 0;
    have     = 1'b0;
    c        = 0;
    for (int j = 0; j < 100; j++) begin
      pix_ce_s = (j % 2 == 0);
      step();
      if (pix_ce_s) begin
        c    = kidx;
        kidx = kidx + 1;
        have = 1'b1;
      end
      chk_small(c, have);
      chk_dflt(0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scan_controller.md
Name: vga_scan_controller

Overview:
- Drives the VGA side of the display path: generates the raster coordinates `hdata`/`vdata` that feed the combinational painters, and turns their colour outputs into registered video signals.
- Aligns colour with registered hsync, vsync and data-enable, blanks outside the active area, and emits line-start and frame-start pulses for game-logic sequencing.
- Sits between the pixel clock domain and the board's VGA DAC/connector. The painters hang off its coordinate outputs.

Parameters:
- VGA_WIDTH, 12, width of the coordinate counters
- HSIZE, 800, active pixels per line
- HFP, 856, hdata value at which hsync pulse starts
- HSP, 976, hdata value at which hsync pulse ends
- HMAX, 1040, total pixels per line
- VSIZE, 600, active lines per frame
- VFP, 637, vdata value at which vsync pulse starts
- VSP, 643, vdata value at which vsync pulse ends
- VMAX, 666, total lines per frame
- HSPP, 1, hsync active polarity
- VSPP, 1, vsync active polarity

Ports:
- clk  input  1  pixel-domain clock
- reset  input  1  asynchronous, active-high reset
- pix_ce  input  1  pixel clock enable; all state advances only when high
- hdata  output  VGA_WIDTH  current horizontal coordinate (to painters)
- vdata  output  VGA_WIDTH  current vertical coordinate (to painters)
- pixel_red  input  8  painter red for current hdata/vdata
- pixel_green  input  8  painter green
- pixel_blue  input  8  painter blue
- video_red  output  8  registered red to DAC
- video_green  output  8  registered green
- video_blue  output  8  registered blue
- video_hsync  output  1  registered hsync
- video_vsync  output  1  registered vsync
- video_de  output  1  registered data enable
- line_start  output  1  one-cycle pulse, first pixel of every line
- frame_start  output  1  one-cycle pulse, pixel (0,0) of every frame

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is asynchronous and active-high.
- Reset values:
  - hdata = 0, vdata = 0
  - video_* colours = 0
  - video_hsync = ~HSPP, video_vsync = ~VSPP
  - video_de = 0, line_start = 0, frame_start = 0
- Counters: on a clk edge with pix_ce = 1:
  - hdata increments; at HMAX-1 it wraps to 0.
  - vdata increments only on the hdata wrap; at VMAX-1 (with hdata = HMAX-1) it wraps to 0.
  - pix_ce = 0 holds every register, including pulses. Pulses are qualified: they assert only on cycles where pix_ce = 1.
- Stage-0 decode (combinational from the counters):
  - hs0 = (hdata >= HFP && hdata < HSP) ? HSPP : ~HSPP
  - vs0 = (vdata >= VFP && vdata < VSP) ? VSPP : ~VSPP
  - de0 = hdata < HSIZE && vdata < VSIZE
- Stage-1 output registers (pix_ce = 1): video_hsync <= hs0, video_vsync <= vs0, video_de <= de0.
- Colour register: video colour <= de0 ? pixel_* : 0. Colours outside the active area are forced to 0 regardless of painter output.
- Latency: fixed 1 pix_ce-cycle from a coordinate to its colour/sync/de at the outputs. All stage-1 outputs stay mutually aligned.
- line_start: registered, equals 1 for the output cycle whose coordinate had hdata = 0.
- frame_start: registered, equals 1 for the output cycle whose coordinate had hdata = 0 and vdata = 0. It coincides with a line_start.
- Boundaries:
  - HMAX-1 → 0 and VMAX-1 → 0 wraps as above.
  - Comparisons are unsigned at VGA_WIDTH bits; HMAX-1 and VMAX-1 must fit in VGA_WIDTH (elaboration-time assertion).
- Reset mid-frame: counters and outputs return to reset values immediately (asynchronously). The first pix_ce cycle after release presents coordinate (0,0). The output cycle after that carries frame_start = 1.
- Ordering constraint: parameters must satisfy HSIZE <= HFP < HSP <= HMAX and VSIZE <= VFP < VSP <= VMAX (assertion).

Decomposition:
- Shared package `vga_pkg`:
  - default 800x600@72 timing constants (HSIZE…VMAX, HSPP, VSPP)
  - VGA_WIDTH
  - `rgb_t` struct (8-bit red/green/blue)
- The painters and this block import these constants so that timing is defined once.
- One sub-module, `vga_axis_counter`, instantiated twice (horizontal and vertical). It holds a counter with enable, wrap at MAX-1, wrap-pulse output, and pulse/active-window decode from FP/SP/SIZE. The vertical instance's enable is pix_ce AND horizontal wrap.

Test Plan:
- Reset then run with pix_ce = 1, default params → hdata sequence 0..1039, then 0; vdata increments to 1 exactly at that wrap; after 1040×666 cycles frame_start pulses again.
- Small params (HSIZE=4, HFP=5, HSP=6, HMAX=8, VSIZE=2, VFP=3, VSP=4, VMAX=5), pixel_red = hdata → video_red shows 0,1,2,3 for output cycles of line 0 and 0 otherwise; video_hsync high only for the output of hdata=5; video_vsync high only for line 3.
- Painter drives constant 0xFF on all channels → video colours 0 whenever video_de = 0, including the whole vertical blanking (vdata 600..665).
- pix_ce toggling 1,0,1,0 → counters advance every other clk; outputs unchanged on pix_ce = 0 cycles; frame_start stays one asserted pix_ce cycle wide.
- Assert reset at hdata=300, vdata=200 for 3 cycles → all outputs at reset values during reset; after release the first output cycle has frame_start = 1, line_start = 1, video_de = 1.
- HSPP = 0, VSPP = 0 → sync outputs idle high and pulse low over the same windows as in the default polarity.
